m_ifetch: RTL and testbench
===========================

M_IFETCH -- requirements
Module: m_ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, byte PC loaded at reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries; only DEPTH=2 is required to be supported.
REQ-003 w_clk  input  1  single clock; all state updates on posedge.
REQ-004 w_rst  input  1  reset, synchronous, active-high.
REQ-005 w_imem_req  output  1  fetch request this cycle.
REQ-006 w_imem_addr  output  12  word address to the instruction memory, equal to r_pc[13:2].
REQ-007 w_imem_data  input  32  instruction word, valid in the cycle after the request.
REQ-008 w_ir  output  32  instruction at buffer head.
REQ-009 w_ir_pc  output  32  byte PC of w_ir.
REQ-010 w_ir_valid  output  1  buffer head valid.
REQ-011 w_ir_ready  input  1  decode accepts head; pop = w_ir_valid & w_ir_ready.
REQ-012 w_redirect  input  1  branch/jump redirect, one-cycle pulse.
REQ-013 w_redirect_pc  input  32  new byte PC; bits [1:0] ignored (treated as 00).

Function
REQ-014 The FSM SHALL have states IDLE and RUN; reset enters IDLE; IDLE moves to RUN unconditionally on the next edge; IDLE issues no request.
REQ-015 In RUN, w_imem_req SHALL be 1 iff !w_redirect && (count + r_inflight - pop) < DEPTH.
REQ-016 On an issued request, r_pc SHALL advance by 4 (mod 2^32), r_inflight SHALL be set and the request PC SHALL be held in r_req_pc; otherwise r_inflight SHALL be cleared.
REQ-017 A response SHALL be pushed {w_imem_data, r_req_pc} at the edge ending the cycle after the request when r_inflight=1 and w_redirect=0.
REQ-018 Latency SHALL be request in cycle t -> w_ir_valid=1 in cycle t+2; there is no bypass.
REQ-019 The buffer SHALL be FIFO order; w_ir, w_ir_pc and w_ir_valid SHALL be driven from registers only (w_ir_valid = count!=0).
REQ-020 Push and pop in the same cycle SHALL both take effect, count unchanged; REQ-015 guarantees a push never occurs to a full buffer.
REQ-021 With w_ir_ready held at 1, sustained throughput SHALL be one instruction per cycle.
REQ-022 With w_ir_ready=0, w_ir and w_ir_pc SHALL remain stable while w_ir_valid=1.
REQ-023 w_redirect=1 in cycle t SHALL flush all entries, discard any response arriving in cycle t, clear r_inflight, load r_pc <= {w_redirect_pc[31:2],2'b00}, and suppress the request in cycle t.
REQ-024 After a redirect in cycle t, the first request SHALL be in cycle t+1 with w_imem_addr = w_redirect_pc[13:2].
REQ-025 A redirect takes priority over a simultaneous push and pop; a pop in the redirect cycle is still considered consumed by decode.
REQ-026 A redirect in IDLE SHALL load r_pc, and the FSM SHALL still move to RUN.
REQ-027 w_imem_addr SHALL wrap modulo 4096 words; r_pc SHALL wrap modulo 2^32.

Reset
REQ-028 While w_rst=1: state=IDLE, r_pc=RESET_PC, count=0, r_inflight=0, w_imem_req=0, w_ir_valid=0, w_ir=0, w_ir_pc=0.
REQ-029 Reset SHALL override redirect, discard any in-flight response, and take effect mid-operation at the next edge.

Verification
REQ-030 Reset release at cycle 0, ready=1, imem[0..3] = 0x00000020, 0x00012020, 0x00222820, 0x00853020 -> requests at addr 0,1,2,3 in cycles 1-4; w_ir_valid from cycle 3; w_ir_pc = 0,4,8,12 on consecutive cycles.
REQ-031 ready=0 from cycle 2 -> exactly 2 entries buffered (pc 0,4); w_imem_req=0 thereafter; w_ir stays 0x00000020; ready=1 -> pops 0,4,8 with no gap or duplicate.
REQ-032 Redirect to 32'h00000103 while 2 entries are buffered and 1 request is in flight -> next cycle w_ir_valid=0 and w_imem_req=1 with addr 12'h040; the first w_ir_pc after the redirect is 32'h00000100; no stale PC appears.
REQ-033 r_pc=32'h00003FFC -> w_imem_addr=12'hFFF, then 12'h000 with w_ir_pc=32'h00004000.
REQ-034 Assert w_rst for one cycle mid-stream with 1 entry buffered and 1 request in flight -> all outputs take their reset values; the in-flight data is never pushed; fetch restarts from RESET_PC.
REQ-035 Random ready/redirect stress for 10k cycles -> the scoreboard sees in-order PCs matching the expected flow; count never exceeds 2 and never underflows.

Source files
------------

// File: rtl/m_ifetch.sv
// Instruction fetch: streams words from imem into a small in-order buffer feeding decode.
// Latency: request in cycle t, head valid in cycle t+2 (no bypass).
// Backpressure: requests stop once buffered + in-flight entries would reach DEPTH.
module m_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        w_clk,
    input  logic        w_rst,
    output logic        w_imem_req,
    output logic [11:0] w_imem_addr,
    input  logic [31:0] w_imem_data,
    output logic [31:0] w_ir,
    output logic [31:0] w_ir_pc,
    output logic        w_ir_valid,
    input  logic        w_ir_ready,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    ent_t          r_buf     [DEPTH];
    ent_t          w_buf_nxt [DEPTH];
    logic          w_pop;
    logic          w_push;
    logic [CW:0]   w_occ;
    logic          unused_rpc_lsb;

    assign unused_rpc_lsb = ^w_redirect_pc[1:0];

    assign w_imem_addr = r_pc[13:2];
    assign w_ir        = r_buf[0].ins;
    assign w_ir_pc     = r_buf[0].pc;
    assign w_ir_valid  = (r_count != '0);

    assign w_pop  = w_ir_valid & w_ir_ready;
    // A redirect discards the response landing in the same cycle.
    assign w_push = r_inflight & ~w_redirect;
    assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_RUN;
            S_RUN:  w_imem_req  = ~w_rst & ~w_redirect & (w_occ < (CW+1)'(DEPTH));
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift-down buffer: entry 0 is always the head, so outputs come straight from flops.
    always_comb begin
        w_buf_nxt   = r_buf;
        w_count_nxt = r_count;
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_buf_nxt[i] = r_buf[i+1];
            end
            w_count_nxt = r_count - CW'(1);
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_count_nxt) begin
                    w_buf_nxt[i] = {w_imem_data, r_req_pc};
                end
            end
            w_count_nxt = w_count_nxt + CW'(1);
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_redirect) begin
            r_pc       <= {w_redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_imem_req;
            if (w_imem_req) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= r_pc;
            end
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= w_buf_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_m_ifetch.sv
// Directed and random-stress bench for m_ifetch with a one-cycle-latency imem model.
module tb_m_ifetch;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b1;
    logic        w_imem_req;
    logic [11:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic [31:0] w_ir;
    logic [31:0] w_ir_pc;
    logic        w_ir_valid;
    logic        w_ir_ready = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [31:0] imem_q = 32'h0;
    logic [31:0] exp_pc;
    logic [11:0] exp_addr;
    logic        rd;
    logic        after_rd;
    int          outst;
    int          npop;

    always #5 w_clk = ~w_clk;

    m_ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .w_clk         (w_clk),
        .w_rst         (w_rst),
        .w_imem_req    (w_imem_req),
        .w_imem_addr   (w_imem_addr),
        .w_imem_data   (w_imem_data),
        .w_ir          (w_ir),
        .w_ir_pc       (w_ir_pc),
        .w_ir_valid    (w_ir_valid),
        .w_ir_ready    (w_ir_ready),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc)
    );

    function automatic logic [31:0] mem_f(input logic [11:0] a);
        case (a)
            12'd0:   return 32'h0000_0020;
            12'd1:   return 32'h0001_2020;
            12'd2:   return 32'h0022_2820;
            12'd3:   return 32'h0085_3020;
            default: return {12'hABC, 8'h00, a};
        endcase
    endfunction

    always @(posedge w_clk) begin
        if (w_imem_req) imem_q <= mem_f(w_imem_addr);
    end
    assign w_imem_data = imem_q;

    task automatic cyc();
        @(posedge w_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"}, w_ir_valid, 1);
        chk({tag, "_pc"}, w_ir_pc, pc);
        chk({tag, "_ir"}, w_ir, mem_f(pc[13:2]));
    endtask

    task automatic chk_req(input string tag, input logic [11:0] addr);
        chk({tag, "_req"}, w_imem_req, 1);
        chk({tag, "_addr"}, w_imem_addr, addr);
    endtask

    task automatic reset_dut();
        cyc();
        w_rst = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0; w_ir_ready = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rst_req", w_imem_req, 0);
        chk("rst_vld", w_ir_valid, 0);
        chk("rst_ir", w_ir, 0);
        chk("rst_irpc", w_ir_pc, 0);
    endtask

    initial begin
        // Streaming from reset with decode always ready
        reset_dut();
        cyc(); w_rst = 1'b0; #1; chk("a_c0_idle", w_imem_req, 0);
        cyc(); #1; chk_req("a_c1", 12'd0); chk("a_c1_vld", w_ir_valid, 0);
        cyc(); #1; chk_req("a_c2", 12'd1); chk("a_c2_vld", w_ir_valid, 0);
        cyc(); #1; chk_req("a_c3", 12'd2); chk_head("a_c3", 32'd0);
        cyc(); #1; chk_req("a_c4", 12'd3); chk_head("a_c4", 32'd4);
        cyc(); #1; chk_head("a_c5", 32'd8);
        cyc(); #1; chk_head("a_c6", 32'd12);

        // Stall fills the buffer, release drains without gaps, then redirects
        reset_dut();
        cyc(); w_rst = 1'b0; #1;
        cyc(); #1; chk_req("b_c1", 12'd0);
        cyc(); w_ir_ready = 1'b0; #1; chk_req("b_c2", 12'd1);
        for (int c = 3; c <= 6; c++) begin
            cyc(); #1;
            chk("b_stall_req", w_imem_req, 0);
            chk_head("b_stall", 32'd0);
        end
        cyc(); w_ir_ready = 1'b1; #1; chk_head("b_c7", 32'd0); chk_req("b_c7", 12'd2);
        cyc(); #1; chk_head("b_c8", 32'd4); chk_req("b_c8", 12'd3);
        cyc(); #1; chk_head("b_c9", 32'd8); chk_req("b_c9", 12'd4);
        cyc(); w_redirect = 1'b1; w_redirect_pc = 32'h0000_0103; #1;
        chk("c_rd_req", w_imem_req, 0); chk_head("c_rd", 32'd12);
        cyc(); w_redirect = 1'b0; #1; chk("c_c11_vld", w_ir_valid, 0); chk_req("c_c11", 12'h040);
        cyc(); #1; chk("c_c12_vld", w_ir_valid, 0); chk_req("c_c12", 12'h041);
        cyc(); #1; chk_head("c_c13", 32'h0000_0100);
        cyc(); #1; chk_head("c_c14", 32'h0000_0104);
        cyc(); w_redirect = 1'b1; w_redirect_pc = 32'h0000_3FFC; #1; chk("d_rd_req", w_imem_req, 0);
        cyc(); w_redirect = 1'b0; #1; chk_req("d_c16", 12'hFFF);
        cyc(); #1; chk_req("d_c17", 12'h000);
        cyc(); #1; chk_head("d_c18", 32'h0000_3FFC);
        cyc(); #1; chk_head("d_c19", 32'h0000_4000);
        cyc(); w_redirect = 1'b1; w_redirect_pc = 32'hFFFF_FFFE; #1;
        cyc(); w_redirect = 1'b0; #1; chk_req("w_c21", 12'hFFF);
        cyc(); #1; chk_req("w_c22", 12'h000);
        cyc(); #1; chk_head("w_c23", 32'hFFFF_FFFC);
        cyc(); #1; chk_head("w_c24", 32'h0000_0000);

        // Redirect while IDLE, then a one-cycle reset mid-stream
        reset_dut();
        cyc(); w_rst = 1'b0; w_redirect = 1'b1; w_redirect_pc = 32'h0000_0200; #1;
        chk("e_c0_req", w_imem_req, 0);
        cyc(); w_redirect = 1'b0; #1; chk_req("e_c1", 12'h080);
        cyc(); #1; chk_req("e_c2", 12'h081);
        cyc(); #1; chk_head("e_c3", 32'h0000_0200);
        cyc(); #1; chk_head("e_c4", 32'h0000_0204);
        cyc(); w_rst = 1'b1; #1; chk("e_rst_req", w_imem_req, 0);
        cyc(); w_rst = 1'b0; #1;
        chk("e_c6_vld", w_ir_valid, 0); chk("e_c6_ir", w_ir, 0);
        chk("e_c6_irpc", w_ir_pc, 0); chk("e_c6_req", w_imem_req, 0);
        cyc(); #1; chk_req("e_c7", 12'd0); chk("e_c7_vld", w_ir_valid, 0);
        cyc(); #1; chk_req("e_c8", 12'd1); chk("e_c8_vld", w_ir_valid, 0);
        cyc(); #1; chk_head("e_c9", 32'd0);

        // Random ready/redirect stress against an in-order PC scoreboard
        reset_dut();
        exp_pc = 32'h0; exp_addr = 12'h0; outst = 0; npop = 0; after_rd = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            cyc();
            if (i == 0) w_rst = 1'b0;
            w_ir_ready    = ($urandom_range(0, 9) < 7);
            rd            = (i > 0) && ($urandom_range(0, 31) == 0);
            w_redirect    = rd;
            w_redirect_pc = $urandom;
            #1;
            if (after_rd && !rd) begin
                chk("s_post_rd_req", w_imem_req, 1);
                chk("s_post_rd_vld", w_ir_valid, 0);
            end
            if (w_ir_valid && w_ir_ready) begin
                chk("s_pop_pc", w_ir_pc, exp_pc);
                chk("s_pop_ir", w_ir, mem_f(exp_pc[13:2]));
                exp_pc = exp_pc + 32'd4;
                outst--;
                npop++;
            end
            if (w_imem_req) begin
                chk("s_req_addr", w_imem_addr, exp_addr);
                exp_addr = exp_addr + 12'd1;
                outst++;
            end
            if (rd) begin
                chk("s_rd_req", w_imem_req, 0);
                exp_pc   = {w_redirect_pc[31:2], 2'b00};
                exp_addr = w_redirect_pc[13:2];
                outst    = 0;
            end
            chk("s_occupancy", (outst >= 0) && (outst <= 2), 1);
            after_rd = rd;
        end
        cyc(); w_redirect = 1'b0;
        chk("s_progress", npop > 1000, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
